// File: rtl/demo_input_sequencer.sv
// demo_input_sequencer: attract-mode replay of a fixed frog-move table onto the four switch lines.
// Define DEMO_LOOP_EN to replay the table forever instead of stopping in DONE.
module demo_input_sequencer #(
  parameter int TICK_DIV    = 250000,
  parameter int START_TICKS = 10,
  parameter int GAP_TICKS   = 20,
  parameter int NUM_STEPS   = 16,
  localparam int STEP_BITS  = $clog2(NUM_STEPS)
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Enable,
  input  logic                 i_Game_Active,
  input  logic                 i_Player_Activity,
  output logic                 o_Switch_1,
  output logic                 o_Switch_2,
  output logic                 o_Switch_3,
  output logic                 o_Switch_4,
  output logic                 o_Demo_Active,
  output logic [STEP_BITS-1:0] o_Step,
  output logic                 o_Done
);
  localparam int CW   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = START_TICKS > GAP_TICKS ? (START_TICKS > 4 ? START_TICKS : 4)
                                                : (GAP_TICKS > 4 ? GAP_TICKS : 4);
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, START, ARM, PRESS, GAP, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [STEP_BITS-1:0] step_q, step_d, step_n;
  logic                 armed_q, armed_d;
  logic [3:0]           sw_q, sw_d;
  logic                 demo_q, demo_d, done_q, done_d;
  logic                 tick, abort, last;

  // Move table, split into direction (0=Up,1=Left,2=Right,3=Down) and hold (press = hold+1 ticks)
  function automatic logic [1:0] dir_of(input logic [STEP_BITS-1:0] s);
    return int'(s) == 11 ? 2'd1 : int'(s) == 12 ? 2'd2 : int'(s) == 13 ? 2'd3 : 2'd0;
  endfunction

  function automatic logic [1:0] hold_of(input logic [STEP_BITS-1:0] s);
    return (int'(s) == 11 || int'(s) == 12) ? 2'd1 : int'(s) == 13 ? 2'd0 : int'(s) >= 14 ? 2'd3 : 2'd2;
  endfunction

  always_comb begin
    tick    = cnt_q == CW'(TICK_DIV - 1);
    abort   = i_Player_Activity && state_q != IDLE;
    last    = step_q == STEP_BITS'(NUM_STEPS - 1);
    state_d = state_q;
    step_n  = step_q;
    if (abort || !i_Enable)
      state_d = IDLE;
    else if (!i_Game_Active && (state_q == PRESS || state_q == GAP))
      state_d = START;
    else
      case (state_q)
        IDLE:    if (armed_q && !i_Player_Activity) state_d = START;
        START:   if (tick && tcnt_q == TW'(START_TICKS - 1)) state_d = ARM;
        ARM:     if (i_Game_Active) state_d = PRESS;
        PRESS:   if (tick && tcnt_q == TW'(hold_of(step_q))) state_d = GAP;
        GAP:     if (tick && tcnt_q == TW'(GAP_TICKS - 1)) begin
`ifdef DEMO_LOOP_EN
          step_n  = last ? '0 : step_q + 1'b1;
          state_d = PRESS;
`else
          step_n  = last ? step_q : step_q + 1'b1;
          state_d = last ? DONE : PRESS;
`endif
        end
        default: ;
      endcase
    step_d  = (state_d == IDLE || state_d == START) ? '0 : step_n;
    // Arming only returns on a disabled cycle so an abort cannot relaunch under the player's hand
    armed_d = abort ? 1'b0 : !i_Enable ? 1'b1 : armed_q;
    cnt_d   = (state_d != state_q || tick) ? '0 : cnt_q + 1'b1;
    tcnt_d  = state_d != state_q ? '0 : tcnt_q + TW'(tick);
    sw_d    = state_d == START ? 4'hF : state_d == PRESS ? 4'b0001 << dir_of(step_d) : 4'h0;
    demo_d  = state_d != IDLE;
`ifdef DEMO_LOOP_EN
    done_d  = 1'b0;
`else
    done_d  = state_d == DONE;
`endif
  end

  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      step_q  <= '0;
      armed_q <= 1'b1;
      sw_q    <= 4'h0;
      demo_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      step_q  <= step_d;
      armed_q <= armed_d;
      sw_q    <= sw_d;
      demo_q  <= demo_d;
      done_q  <= done_d;
    end

  assign o_Switch_1    = sw_q[0];
  assign o_Switch_2    = sw_q[1];
  assign o_Switch_3    = sw_q[2];
  assign o_Switch_4    = sw_q[3];
  assign o_Demo_Active = demo_q;
  assign o_Step        = step_q;
  assign o_Done        = done_q;
endmodule

// File: tb/tb_demo_input_sequencer.sv
// tb_demo_input_sequencer: directed checks of demo start, move timing, abort, game over, end of table and async reset.
`timescale 1ns/1ps
module tb_demo_input_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic i_Enable = 1'b0, i_Game_Active = 1'b0, i_Player_Activity = 1'b0;
  logic o_Switch_1, o_Switch_2, o_Switch_3, o_Switch_4, o_Demo_Active, o_Done;
  logic [3:0] o_Step;
  logic [3:0] sw;
  int checks = 0, failures = 0;

  assign sw = {o_Switch_4, o_Switch_3, o_Switch_2, o_Switch_1};

  always #5 clk = ~clk;

  demo_input_sequencer #(.TICK_DIV(4), .START_TICKS(2), .GAP_TICKS(3), .NUM_STEPS(16)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(i_Enable), .i_Game_Active(i_Game_Active),
    .i_Player_Activity(i_Player_Activity), .o_Switch_1(o_Switch_1), .o_Switch_2(o_Switch_2),
    .o_Switch_3(o_Switch_3), .o_Switch_4(o_Switch_4), .o_Demo_Active(o_Demo_Active),
    .o_Step(o_Step), .o_Done(o_Done));

  // Count consecutive negedges on which the switches show pat (bounded)
  task automatic measure(input logic [3:0] pat, output int n);
    n = 0;
    while (sw == pat && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic start_game;
    i_Enable = 1'b0; i_Game_Active = 1'b0; i_Player_Activity = 1'b0;
    repeat (2) @(negedge clk);
    i_Enable = 1'b1;
    repeat (10) @(negedge clk);
    i_Game_Active = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sw !== 4'h0) begin failures++; $display("FAIL reset_sw got=%b want=0000", sw); end
    checks++; if (o_Demo_Active !== 1'b0) begin failures++; $display("FAIL reset_demo got=%b want=0", o_Demo_Active); end
    checks++; if (o_Step !== 4'd0) begin failures++; $display("FAIL reset_step got=%0d want=0", o_Step); end
    checks++; if (o_Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", o_Done); end
  endtask

  task automatic test_start;
    int n;
    i_Enable = 1'b1;
    @(negedge clk);
    checks++; if (o_Demo_Active !== 1'b1) begin failures++; $display("FAIL start_demo got=%b want=1", o_Demo_Active); end
    measure(4'hF, n);
    checks++; if (n != 8) begin failures++; $display("FAIL start_len got=%0d want=8", n); end
    checks++; if (sw !== 4'h0 || o_Demo_Active !== 1'b1) begin failures++; $display("FAIL arm_out got sw=%b demo=%b want 0000/1", sw, o_Demo_Active); end
    repeat (6) @(negedge clk);
    checks++; if (sw !== 4'h0 || o_Demo_Active !== 1'b1) begin failures++; $display("FAIL arm_wait got sw=%b demo=%b want 0000/1", sw, o_Demo_Active); end
    i_Game_Active = 1'b1;
    @(negedge clk);
    checks++; if (o_Step !== 4'd0) begin failures++; $display("FAIL step0_idx got=%0d want=0", o_Step); end
    measure(4'b0001, n);
    checks++; if (n != 12) begin failures++; $display("FAIL step0_len got=%0d want=12", n); end
    checks++; if (sw !== 4'h0) begin failures++; $display("FAIL step0_gap got=%b want=0000", sw); end
  endtask

  task automatic test_timing;
    int n;
    n = 0;
    while (!(o_Step == 4'd11 && sw != 4'h0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 1000) begin failures++; $display("FAIL step11_reach got=timeout want=step 11 press"); end
    checks++; if (o_Step !== 4'd11) begin failures++; $display("FAIL step11_idx got=%0d want=11", o_Step); end
    measure(4'b0010, n);
    checks++; if (n != 8) begin failures++; $display("FAIL step11_len got=%0d want=8", n); end
    measure(4'b0000, n);
    checks++; if (n != 12) begin failures++; $display("FAIL gap11_len got=%0d want=12", n); end
    checks++; if (o_Step !== 4'd12) begin failures++; $display("FAIL step12_idx got=%0d want=12", o_Step); end
    measure(4'b0100, n);
    checks++; if (n != 8) begin failures++; $display("FAIL step12_len got=%0d want=8", n); end
    measure(4'b0000, n);
    checks++; if (n != 12) begin failures++; $display("FAIL gap12_len got=%0d want=12", n); end
    measure(4'b1000, n);
    checks++; if (n != 4) begin failures++; $display("FAIL step13_len got=%0d want=4", n); end
  endtask

  task automatic test_end;
    int n;
    logic seen_done;
    measure(4'b0000, n);
    checks++; if (n != 12) begin failures++; $display("FAIL gap13_len got=%0d want=12", n); end
    checks++; if (o_Step !== 4'd14) begin failures++; $display("FAIL step14_idx got=%0d want=14", o_Step); end
    measure(4'b0001, n);
    checks++; if (n != 16) begin failures++; $display("FAIL step14_len got=%0d want=16", n); end
`ifdef DEMO_LOOP_EN
    n = 0; seen_done = 1'b0;
    while (!(o_Step == 4'd0 && sw != 4'h0) && n < 1000) begin
      seen_done |= o_Done;
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 1000) begin failures++; $display("FAIL wrap_reach got=timeout want=step 0 press"); end
    checks++; if (sw !== 4'b0001) begin failures++; $display("FAIL wrap_sw got=%b want=0001", sw); end
    checks++; if (seen_done !== 1'b0 || o_Done !== 1'b0) begin failures++; $display("FAIL wrap_done got=%b want=0", seen_done | o_Done); end
`else
    n = 0; seen_done = 1'b0;
    while (!o_Done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 1000) begin failures++; $display("FAIL done_reach got=timeout want=o_Done"); end
    checks++; if (o_Step !== 4'd15) begin failures++; $display("FAIL done_step got=%0d want=15", o_Step); end
    checks++; if (sw !== 4'h0 || o_Demo_Active !== 1'b1) begin failures++; $display("FAIL done_out got sw=%b demo=%b want 0000/1", sw, o_Demo_Active); end
    repeat (20) @(negedge clk);
    checks++; if (o_Done !== 1'b1 || sw !== 4'h0) begin failures++; $display("FAIL done_hold got done=%b sw=%b want 1/0000", o_Done, sw); end
`endif
  endtask

  task automatic test_abort;
    start_game;
    repeat (4) @(negedge clk);
    checks++; if (sw !== 4'b0001) begin failures++; $display("FAIL abort_pre got=%b want=0001", sw); end
    i_Player_Activity = 1'b1;
    @(negedge clk);
    i_Player_Activity = 1'b0;
    checks++; if (sw !== 4'h0 || o_Demo_Active !== 1'b0) begin failures++; $display("FAIL abort_out got sw=%b demo=%b want 0000/0", sw, o_Demo_Active); end
    repeat (5) @(negedge clk);
    checks++; if (sw !== 4'h0 || o_Demo_Active !== 1'b0) begin failures++; $display("FAIL abort_stay got sw=%b demo=%b want 0000/0", sw, o_Demo_Active); end
    i_Enable = 1'b0;
    @(negedge clk);
    i_Enable = 1'b1;
    @(negedge clk);
    checks++; if (sw !== 4'hF || o_Demo_Active !== 1'b1) begin failures++; $display("FAIL rearm got sw=%b demo=%b want 1111/1", sw, o_Demo_Active); end
  endtask

  task automatic test_game_over;
    int n;
    start_game;
    n = 0;
    while (!(o_Step == 4'd5 && sw == 4'h0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 1000) begin failures++; $display("FAIL gap5_reach got=timeout want=step 5 gap"); end
    repeat (3) @(negedge clk);
    i_Game_Active = 1'b0;
    @(negedge clk);
    checks++; if (sw !== 4'hF || o_Step !== 4'd0) begin failures++; $display("FAIL gameover got sw=%b step=%0d want 1111/0", sw, o_Step); end
    measure(4'hF, n);
    checks++; if (n != 8) begin failures++; $display("FAIL restart_len got=%0d want=8", n); end
  endtask

  task automatic test_async_reset;
    i_Enable = 1'b0;
    @(negedge clk);
    i_Enable = 1'b1;
    @(negedge clk);
    checks++; if (sw !== 4'hF) begin failures++; $display("FAIL pre_reset got=%b want=1111", sw); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sw !== 4'h0 || o_Demo_Active !== 1'b0) begin failures++; $display("FAIL async_reset got sw=%b demo=%b want 0000/0", sw, o_Demo_Active); end
    @(negedge clk);
    i_Enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sw !== 4'h0 || o_Step !== 4'd0 || o_Demo_Active !== 1'b0) begin failures++; $display("FAIL post_reset got sw=%b step=%0d demo=%b want 0000/0/0", sw, o_Step, o_Demo_Active); end
    i_Enable = 1'b1;
    @(negedge clk);
    checks++; if (sw !== 4'hF) begin failures++; $display("FAIL post_reset_start got=%b want=1111", sw); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_start;
    test_timing;
    test_end;
    test_abort;
    test_game_over;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
